msg_scroll_sequencer: RTL and testbench
=======================================

Name: msg_scroll_sequencer

Overview:
- Upstream feeder for the 5-bit alphanumeric segment decoder.
- Holds a writable message buffer of 5-bit character codes and scrolls the message across NUM_DIGITS time-multiplexed 14-segment digits.
- Each cycle it presents one character code plus a one-hot digit select. The decoder converts code_out to segments, and the board drives the selected digit's common line.

Parameters:
- MSG_DEPTH, 16, number of character slots in the message buffer (power of 2).
- NUM_DIGITS, 4, number of physical digits multiplexed.
- MUX_DIV, 1000, clock cycles per digit refresh slot (>=2).
- SCROLL_DIV, 5000000, clock cycles per one-character scroll step (>=2).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- wr_en  in  1  write strobe for the message buffer.
- wr_addr  in  log2(MSG_DEPTH)  buffer slot to write.
- wr_char  in  5  character code; bit4..bit0 map to decoder inputs a..e.
- msg_len  in  log2(MSG_DEPTH)+1  active message length, 0..MSG_DEPTH.
- run  in  1  1 = scroll, 0 = freeze the current window.
- code_out  out  5  character for the selected digit; bit4=a .. bit0=e.
- digit_sel  out  NUM_DIGITS  one-hot digit enable.
- blank  out  1  1 = selected digit must be dark; the decoder output is gated externally.
- scroll_wrap  out  1  one-cycle pulse when the head wraps to slot 0.

Behaviour:
- Reset (asynchronous assertion, synchronous release):
  - buffer all 5'b0; head=0; digit_idx=0; both prescalers=0.
  - code_out=0, digit_sel=0, blank=1, scroll_wrap=0.
- Writes: when wr_en=1, buf[wr_addr]<=wr_char at the clock edge. Writes are accepted in every state.
- Read/write same slot in the same cycle: code_out shows the old value; the new value appears from the next refresh.
- Effective length L = min(msg_len, MSG_DEPTH).
- Multiplex:
  - The mux prescaler counts 0..MUX_DIV-1 continuously after reset, independent of run.
  - At terminal count, digit_idx advances 0..NUM_DIGITS-1 and wraps to 0.
- Outputs are registered with 1-cycle latency from the internal state:
  - digit_sel = one-hot(digit_idx).
  - pos = (head + digit_idx) mod L.
  - code_out = buf[pos].
  - blank = 1 if L==0 or digit_idx >= L; otherwise 0.
  - When blank=1, code_out=0.
- digit_sel becomes 4'b0001 on the first clock after reset release and is never all-zero afterwards.
- FSM, 2 states:
  - IDLE: scroll prescaler held at 0, head held. IDLE->SCROLL when run=1 and L>=2.
  - SCROLL: scroll prescaler counts 0..SCROLL_DIV-1. At terminal count head<=head+1, or 0 if head==L-1, and scroll_wrap pulses in that same cycle. SCROLL->IDLE when run=0 or L<2; the prescaler clears and head is kept.
- L<=1 never scrolls. L<NUM_DIGITS still scrolls; window positions >= L are blank.
- msg_len changes while running: if head >= new L, head<=0 on the next edge with no scroll_wrap pulse. The prescaler is not disturbed.
- run toggling only pauses or resumes; head is never reset by run.
- Mux and scroll terminal counts in the same cycle: both apply. The new head is used from the next cycle.
- Reset mid-operation: all state returns to reset values immediately; buffer contents are lost.

Decomposition:
- Shared package:
  - CHAR_W=5.
  - character-code constants for the decoder alphabet (CH_A..CH_Z, CH_BLANK policy).
  - state enum {IDLE, SCROLL}.
- One sub-module: tick_gen, a parameterised modulo-N counter with enable, synchronous clear, and terminal-count pulse. It is instantiated twice, for MUX_DIV and SCROLL_DIV.

Test Plan (bench uses NUM_DIGITS=4, MSG_DEPTH=16, MUX_DIV=2, SCROLL_DIV=8):
- Reset, then idle with msg_len=0 -> digit_sel cycles 0001,0010,0100,1000 every 2 cycles; blank=1 and code_out=0 throughout; scroll_wrap never pulses.
- Write slots 0..5 = 5'd7,8,11,11,14,25; msg_len=6; run=0 -> digit0..3 show 7,8,11,11 with blank=0.
- run=1 -> head advances every 8 cycles. After the 6th step, head=0 and scroll_wrap is a single 1-cycle pulse. Window at head=4 shows 14,25,7,8 (wrap-around).
- msg_len=3, run=1 -> digit3 blank=1. Set msg_len=2 while head=2 -> head=0 next cycle, no scroll_wrap.
- Write slot 1 = 5'd20 on the same cycle digit1 is read -> that cycle shows the old 8; the next digit1 refresh shows 20.
- Assert rst_n=0 mid-scroll with head=3 -> outputs go immediately to code_out=0, digit_sel=0, blank=1. After release, buffer reads 0 and head=0.

Source files
------------

// File: rtl/msg_scroll_sequencer_pkg.sv
// Shared definitions for the message scroll sequencer.
//   CHAR_W          width of one character code (bit4 = decoder input a .. bit0 = e)
//   CH_A .. CH_Z    alphabet codes understood by the 5-bit segment decoder
//   CH_BLANK        code driven on code_out while a digit is dark; darkness itself
//                   is signalled by the blank output, the code only keeps the bus quiet
//   scroll_state_e  scroll controller states
package msg_scroll_sequencer_pkg;

    localparam int CHAR_W = 5;

    typedef logic [CHAR_W-1:0] char_t;

    localparam char_t CH_A = 5'd0,  CH_B = 5'd1,  CH_C = 5'd2,  CH_D = 5'd3;
    localparam char_t CH_E = 5'd4,  CH_F = 5'd5,  CH_G = 5'd6,  CH_H = 5'd7;
    localparam char_t CH_I = 5'd8,  CH_J = 5'd9,  CH_K = 5'd10, CH_L = 5'd11;
    localparam char_t CH_M = 5'd12, CH_N = 5'd13, CH_O = 5'd14, CH_P = 5'd15;
    localparam char_t CH_Q = 5'd16, CH_R = 5'd17, CH_S = 5'd18, CH_T = 5'd19;
    localparam char_t CH_U = 5'd20, CH_V = 5'd21, CH_W = 5'd22, CH_X = 5'd23;
    localparam char_t CH_Y = 5'd24, CH_Z = 5'd25;

    localparam char_t CH_BLANK = 5'd0;

    typedef enum logic {
        IDLE,
        SCROLL
    } scroll_state_e;

endpackage

// File: rtl/msg_scroll_sequencer_tick.sv
// tick_gen: modulo-N counter used as a clock-enable prescaler.
//   clk, rst_n  clock and asynchronous active-low reset
//   en_i        advance the count this cycle
//   clr_i       synchronous clear to 0 (wins over en_i)
//   tick_o      high in the cycle the counter sits at N-1 while enabled;
//               the counter returns to 0 on that edge
module tick_gen #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic [CW-1:0] cnt_q;

    // NOTE: sequential state is always updated with non-blocking assignments so
    // every register samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    assign tick_o = en_i && !clr_i && (cnt_q == LAST);

endmodule

// File: rtl/msg_scroll_sequencer.sv
// msg_scroll_sequencer: scrolls a writable message across time-multiplexed digits.
//   clk, rst_n              clock, asynchronous active-low reset
//   wr_en/wr_addr/wr_char   write port of the message buffer (any state)
//   msg_len                 active length, clamped to MSG_DEPTH
//   run                     1 = scroll, 0 = freeze the current window
//   code_out                character for the selected digit (0 while blank)
//   digit_sel               one-hot digit enable
//   blank                   selected digit must be dark
//   scroll_wrap             one-cycle pulse, high in the cycle head becomes 0 by scrolling
module msg_scroll_sequencer
    import msg_scroll_sequencer_pkg::*;
#(
    parameter int MSG_DEPTH  = 16,
    parameter int NUM_DIGITS = 4,
    parameter int MUX_DIV    = 1000,
    parameter int SCROLL_DIV = 5000000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr_en,
    input  logic [$clog2(MSG_DEPTH)-1:0] wr_addr,
    input  logic [CHAR_W-1:0]            wr_char,
    input  logic [$clog2(MSG_DEPTH):0]   msg_len,
    input  logic                         run,
    output logic [CHAR_W-1:0]            code_out,
    output logic [NUM_DIGITS-1:0]        digit_sel,
    output logic                         blank,
    output logic                         scroll_wrap
);

    localparam int AW = $clog2(MSG_DEPTH);
    localparam int LW = AW + 1;
    localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    char_t           msg_q [MSG_DEPTH];
    logic [AW-1:0]   head_q;
    logic [DW-1:0]   digit_idx_q;
    scroll_state_e   state_q;
    logic            scroll_wrap_q;
    char_t           code_q;
    logic [NUM_DIGITS-1:0] digit_sel_q;
    logic            blank_q;

    logic [LW-1:0]   len_eff;
    logic            can_scroll;
    logic            scroll_en;
    logic            mux_tick;
    logic            scroll_tick;
    logic            head_oob;
    logic            head_last;
    logic            digit_blank;
    logic [AW-1:0]   pos;

    assign len_eff    = (msg_len > LW'(MSG_DEPTH)) ? LW'(MSG_DEPTH) : msg_len;
    assign can_scroll = (len_eff >= LW'(2));
    // The prescaler only runs while the FSM is in SCROLL and the conditions to
    // stay there still hold, so it is already cleared on the edge that leaves SCROLL.
    assign scroll_en  = (state_q == SCROLL) && run && can_scroll;
    assign head_oob   = ({1'b0, head_q} >= len_eff);
    assign head_last  = ({1'b0, head_q} == len_eff - LW'(1));

    tick_gen #(.N(MUX_DIV)) u_mux_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (1'b1),
        .clr_i  (1'b0),
        .tick_o (mux_tick)
    );

    tick_gen #(.N(SCROLL_DIV)) u_scroll_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (scroll_en),
        .clr_i  (!scroll_en),
        .tick_o (scroll_tick)
    );

    // NOTE: the buffer must read as zero after reset, so it is built from
    // resettable flops rather than a RAM macro (which cannot be reset).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MSG_DEPTH; i++) begin
                msg_q[i] <= '0;
            end
        end else if (wr_en) begin
            msg_q[wr_addr] <= wr_char;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_idx_q <= '0;
        end else if (mux_tick) begin
            digit_idx_q <= (digit_idx_q == DW'(NUM_DIGITS - 1)) ? '0 : digit_idx_q + 1'b1;
        end
    end

    // Scroll controller. A shortened message that leaves head past its end pulls
    // head back to 0 silently; that takes priority over a coincident scroll step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            head_q        <= '0;
            scroll_wrap_q <= 1'b0;
        end else begin
            scroll_wrap_q <= 1'b0;
            case (state_q)
                IDLE:    if (run && can_scroll)   state_q <= SCROLL;
                SCROLL:  if (!run || !can_scroll) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
            if (head_oob) begin
                head_q <= '0;
            end else if (scroll_tick) begin
                if (head_last) begin
                    head_q        <= '0;
                    scroll_wrap_q <= 1'b1;
                end else begin
                    head_q <= head_q + 1'b1;
                end
            end
        end
    end

    // NOTE: every signal assigned in always_comb gets a default first so no
    // path leaves it unassigned and infers a latch.
    always_comb begin
        pos         = '0;
        digit_blank = (len_eff == '0) || (int'(digit_idx_q) >= int'(len_eff));
        // Full modulo keeps the slot correct even in the single cycle where a
        // shortened message still has head >= L.
        if (!digit_blank) begin
            pos = AW'((int'(head_q) + int'(digit_idx_q)) % int'(len_eff));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_q      <= '0;
            digit_sel_q <= '0;
            blank_q     <= 1'b1;
        end else begin
            digit_sel_q <= NUM_DIGITS'(1) << digit_idx_q;
            blank_q     <= digit_blank;
            code_q      <= digit_blank ? CH_BLANK : msg_q[pos];
        end
    end

    assign code_out    = code_q;
    assign digit_sel   = digit_sel_q;
    assign blank       = blank_q;
    assign scroll_wrap = scroll_wrap_q;

endmodule

// File: tb/tb_msg_scroll_sequencer.sv
// Self-checking bench for msg_scroll_sequencer: a hand-written vector table for
// the first cycles after reset, hand-checked corner sequences, then randomized
// traffic, with every cycle also compared against a behavioural model.
module tb_msg_scroll_sequencer;
    import msg_scroll_sequencer_pkg::*;

    localparam int MSG_DEPTH  = 16;
    localparam int NUM_DIGITS = 4;
    localparam int MUX_DIV    = 2;
    localparam int SCROLL_DIV = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [4:0] wr_char;
    logic [4:0] msg_len;
    logic       run;
    logic [4:0] code_out;
    logic [3:0] digit_sel;
    logic       blank;
    logic       scroll_wrap;

    always #5 clk = ~clk;

    msg_scroll_sequencer #(
        .MSG_DEPTH  (MSG_DEPTH),
        .NUM_DIGITS (NUM_DIGITS),
        .MUX_DIV    (MUX_DIV),
        .SCROLL_DIV (SCROLL_DIV)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_char     (wr_char),
        .msg_len     (msg_len),
        .run         (run),
        .code_out    (code_out),
        .digit_sel   (digit_sel),
        .blank       (blank),
        .scroll_wrap (scroll_wrap)
    );

    // ---------------- behavioural model ----------------
    // Digit index is derived from the cycle count since reset; head moves one
    // slot after SCROLL_DIV consecutive cycles of active scrolling, where
    // scrolling becomes active one cycle after run=1 with L>=2 is seen.
    logic [4:0] m_buf [MSG_DEPTH];
    int         m_head, m_cyc, m_active_cnt, m_L, m_d;
    bit         m_running, m_active, m_step;
    logic [3:0] m_sel;
    logic [4:0] m_code;
    logic       m_blank, m_wrap;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MSG_DEPTH; i++) m_buf[i] = 5'd0;
            m_head = 0; m_cyc = 0; m_active_cnt = 0; m_running = 0;
            m_sel = 4'd0; m_code = 5'd0; m_blank = 1'b1; m_wrap = 1'b0;
        end else begin
            m_L     = (int'(msg_len) > MSG_DEPTH) ? MSG_DEPTH : int'(msg_len);
            m_d     = (m_cyc / MUX_DIV) % NUM_DIGITS;
            m_sel   = 4'(1 << m_d);
            m_blank = (m_L == 0) || (m_d >= m_L);
            m_code  = m_blank ? 5'd0 : m_buf[(m_head + m_d) % m_L];
            m_wrap  = 1'b0;
            m_active = m_running && run && (m_L >= 2);
            if (m_active) m_active_cnt++; else m_active_cnt = 0;
            m_step = (m_active_cnt == SCROLL_DIV);
            if (m_step) m_active_cnt = 0;
            if (m_head >= m_L) begin
                m_head = 0;
            end else if (m_step) begin
                m_head = (m_head + 1) % m_L;
                m_wrap = (m_head == 0);
            end
            m_running = run && (m_L >= 2);
            if (wr_en) m_buf[wr_addr] = wr_char;
            m_cyc++;
        end
    end

    // ---------------- checking helpers ----------------
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
        check($sformatf("model@%0t", $time),
              {21'd0, scroll_wrap, blank, digit_sel, code_out},
              {21'd0, m_wrap, m_blank, m_sel, m_code});
    endtask

    logic [4:0] win_code  [NUM_DIGITS];
    logic       win_blank [NUM_DIGITS];
    int         win_wraps;

    task automatic collect_window(input int ncyc);
        for (int d = 0; d < NUM_DIGITS; d++) begin
            win_code[d]  = 'x;
            win_blank[d] = 1'bx;
        end
        win_wraps = 0;
        for (int c = 0; c < ncyc; c++) begin
            cycle();
            if (scroll_wrap) win_wraps++;
            for (int d = 0; d < NUM_DIGITS; d++) begin
                if (digit_sel == 4'(1 << d)) begin
                    win_code[d]  = code_out;
                    win_blank[d] = blank;
                end
            end
        end
    endtask

    // codes/blanks packed digit3..digit0
    task automatic check_window(input string name, input logic [19:0] codes, input logic [3:0] blanks);
        for (int d = 0; d < NUM_DIGITS; d++) begin
            check($sformatf("%s digit%0d", name, d),
                  {26'd0, win_blank[d], win_code[d]},
                  {26'd0, blanks[d], codes[d*5 +: 5]});
        end
    endtask

    task automatic wait_head(input int h, input int budget, input string name);
        int n;
        n = 0;
        while (m_head != h && n < budget) begin
            cycle();
            n++;
        end
        if (m_head != h) check({name, " timeout"}, 32'(m_head), 32'(h));
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       wr_en;
        logic [3:0] wr_addr;
        logic [4:0] wr_char;
        logic [4:0] msg_len;
        logic       run;
        logic [3:0] exp_sel;
        logic [4:0] exp_code;
        logic       exp_blank;
        logic       exp_wrap;
    } vec_t;

    vec_t vecs [16];

    function automatic vec_t mk(logic we, logic [3:0] a, logic [4:0] ch, logic [4:0] len,
                                logic r, logic [3:0] sel, logic [4:0] code, logic bl);
        vec_t v;
        v.wr_en = we; v.wr_addr = a; v.wr_char = ch; v.msg_len = len; v.run = r;
        v.exp_sel = sel; v.exp_code = code; v.exp_blank = bl; v.exp_wrap = 1'b0;
        return v;
    endfunction

    initial begin
        int n;

        // Idle with msg_len=0 while loading "HILLOZ", then msg_len=6 frozen at head 0.
        vecs[0]  = mk(1, 4'd0, CH_H, 5'd0, 0, 4'b0001, 5'd0, 1);
        vecs[1]  = mk(1, 4'd1, CH_I, 5'd0, 0, 4'b0001, 5'd0, 1);
        vecs[2]  = mk(1, 4'd2, CH_L, 5'd0, 0, 4'b0010, 5'd0, 1);
        vecs[3]  = mk(1, 4'd3, CH_L, 5'd0, 0, 4'b0010, 5'd0, 1);
        vecs[4]  = mk(1, 4'd4, CH_O, 5'd0, 0, 4'b0100, 5'd0, 1);
        vecs[5]  = mk(1, 4'd5, CH_Z, 5'd0, 0, 4'b0100, 5'd0, 1);
        vecs[6]  = mk(0, 4'd0, 5'd0, 5'd0, 0, 4'b1000, 5'd0, 1);
        vecs[7]  = mk(0, 4'd0, 5'd0, 5'd0, 0, 4'b1000, 5'd0, 1);
        vecs[8]  = mk(0, 4'd0, 5'd0, 5'd6, 0, 4'b0001, CH_H, 0);
        vecs[9]  = mk(0, 4'd0, 5'd0, 5'd6, 0, 4'b0001, CH_H, 0);
        vecs[10] = mk(0, 4'd0, 5'd0, 5'd6, 0, 4'b0010, CH_I, 0);
        vecs[11] = mk(0, 4'd0, 5'd0, 5'd6, 0, 4'b0010, CH_I, 0);
        vecs[12] = mk(0, 4'd0, 5'd0, 5'd6, 0, 4'b0100, CH_L, 0);
        vecs[13] = mk(0, 4'd0, 5'd0, 5'd6, 0, 4'b0100, CH_L, 0);
        vecs[14] = mk(0, 4'd0, 5'd0, 5'd6, 0, 4'b1000, CH_L, 0);
        vecs[15] = mk(0, 4'd0, 5'd0, 5'd6, 0, 4'b1000, CH_L, 0);

        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_char = '0; msg_len = '0; run = 1'b0;
        repeat (3) cycle();
        check("reset outputs", {21'd0, scroll_wrap, blank, digit_sel, code_out},
              {21'd0, 1'b0, 1'b1, 4'b0000, 5'd0});
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            wr_en = vecs[i].wr_en; wr_addr = vecs[i].wr_addr; wr_char = vecs[i].wr_char;
            msg_len = vecs[i].msg_len; run = vecs[i].run;
            cycle();
            check($sformatf("table[%0d]", i),
                  {21'd0, scroll_wrap, blank, digit_sel, code_out},
                  {21'd0, vecs[i].exp_wrap, vecs[i].exp_blank, vecs[i].exp_sel, vecs[i].exp_code});
        end
        wr_en = 1'b0;

        // Scroll: six steps of 8 cycles plus one cycle to enter SCROLL -> wrap after 49 cycles.
        run = 1'b1;
        n = 0;
        do begin
            cycle();
            n++;
        end while (!scroll_wrap && n < 100);
        check("cycles to first wrap", 32'(n), 32'd49);
        run = 1'b0;
        collect_window(10);
        check("wrap pulse width", 32'(win_wraps), 32'd0);
        check_window("window head0", {CH_L, CH_L, CH_I, CH_H}, 4'b0000);

        run = 1'b1;
        wait_head(4, 100, "head4");
        run = 1'b0;
        collect_window(9);
        check_window("window head4", {CH_I, CH_H, CH_Z, CH_O}, 4'b0000);

        // Short message still scrolls; digit3 lies beyond L=3.
        msg_len = 5'd3; run = 1'b1;
        collect_window(8);
        check("len3 digit3 blank", {31'd0, win_blank[3]}, 32'd1);
        check("len3 digit3 code", 32'(win_code[3]), 32'd0);
        wait_head(2, 40, "head2");
        msg_len = 5'd2;
        cycle();
        check("shrink no wrap", {31'd0, scroll_wrap}, 32'd0);
        run = 1'b0;
        collect_window(9);
        check("shrink wrap count", 32'(win_wraps), 32'd0);
        check_window("window len2", {5'd0, 5'd0, CH_I, CH_H}, 4'b1100);

        // Write slot 1 on the last cycle digit1 is sampled.
        n = 0;
        while ((m_cyc % 8) != 3 && n < 10) begin
            cycle();
            n++;
        end
        wr_en = 1'b1; wr_addr = 4'd1; wr_char = CH_U;
        cycle();
        wr_en = 1'b0;
        check("rw collide sel", 32'(digit_sel), 32'b0010);
        check("rw collide old code", 32'(code_out), 32'(CH_I));
        n = 0;
        do begin
            cycle();
            n++;
        end while (digit_sel != 4'b0010 && n < 12);
        check("rw next refresh code", 32'(code_out), 32'(CH_U));

        // Reset mid-scroll with head=3.
        msg_len = 5'd6; run = 1'b1;
        wait_head(3, 100, "head3");
        #2 rst_n = 1'b0;
        #1;
        check("async reset outputs", {21'd0, scroll_wrap, blank, digit_sel, code_out},
              {21'd0, 1'b0, 1'b1, 4'b0000, 5'd0});
        @(negedge clk);
        rst_n = 1'b1; run = 1'b0;
        cycle();
        check("first sel after release", 32'(digit_sel), 32'b0001);
        collect_window(8);
        check_window("window after reset", 20'd0, 4'b0000);

        // Randomized traffic against the model.
        run = 1'b1; msg_len = 5'd5;
        for (int i = 0; i < 3000; i++) begin
            wr_en   = ($urandom_range(0, 3) == 0);
            wr_addr = 4'($urandom_range(0, 15));
            wr_char = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 59) == 0) msg_len = 5'($urandom_range(0, 20));
            if ($urandom_range(0, 79) == 0) run = ~run;
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
